// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the request/data inputs and grant/mux outputs shared by the
// round-robin arbiter and the four sources/downstream consumer.
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       dout;
  logic       valid;

  modport master (output req, din, input grant, sel, dout, valid);
  modport slave  (input req, din, output grant, sel, dout, valid);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 1-bit 4:1 mux among four requesters.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD cycles under contention.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  mux4_rr_arbiter_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..15");
  end

  state_t     r_state, w_state_nxt;
  logic [3:0] r_grant, w_grant_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic       r_dout, w_dout_nxt;
  logic       r_valid, w_valid_nxt;
  logic [2:0] w_pick_any;
  logic       w_take;
  logic [1:0] w_take_idx;

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  logic [3:0] r_hold_cnt, w_hold_nxt;
  logic [2:0] w_pick_other;
`endif

  // Returns {found, index} of the first set bit searching p, p+1, p+2, p+3 mod 4.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (r[p + 2'(i)]) res = {1'b1, p + 2'(i)};
    end
    return res;
  endfunction

  assign w_pick_any = pick(bus.req, r_ptr);
`ifdef ARB_TIMEOUT_EN
  assign w_pick_other = pick(bus.req & ~r_grant, r_ptr);
`endif

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_valid;
    w_take      = 1'b0;
    w_take_idx  = 2'b00;
`ifdef ARB_TIMEOUT_EN
    w_hold_nxt  = r_hold_cnt;
`endif

    case (r_state)
      ST_IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_pick_any[2]) begin
          w_take     = 1'b1;
          w_take_idx = w_pick_any[1:0];
        end
      end
      ST_GRANT: begin
        // r_sel always equals the current owner while granted.
        w_dout_nxt  = bus.din[r_sel];
        w_valid_nxt = 1'b1;
        if (bus.req[r_sel]) begin
`ifdef ARB_TIMEOUT_EN
          if (r_hold_cnt == HOLD_LAST) begin
            if (w_pick_other[2]) begin
              w_take     = 1'b1;
              w_take_idx = w_pick_other[1:0];
            end else begin
              w_hold_nxt = 4'd0;
            end
          end else begin
            w_hold_nxt = r_hold_cnt + 4'd1;
          end
`endif
        end else if (w_pick_any[2]) begin
          w_take     = 1'b1;
          w_take_idx = w_pick_any[1:0];
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 4'b0000;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 4'b0000;
      end
    endcase

    if (w_take) begin
      w_state_nxt = ST_GRANT;
      w_grant_nxt = 4'b0001 << w_take_idx;
      w_sel_nxt   = w_take_idx;
      w_ptr_nxt   = w_take_idx + 2'd1;
`ifdef ARB_TIMEOUT_EN
      w_hold_nxt  = 4'd0;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= 4'b0000;
      r_sel      <= 2'b00;
      r_ptr      <= 2'b00;
      r_dout     <= 1'b0;
      r_valid    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= 4'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_sel      <= w_sel_nxt;
      r_ptr      <= w_ptr_nxt;
      r_dout     <= w_dout_nxt;
      r_valid    <= w_valid_nxt;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= w_hold_nxt;
`endif
    end
  end

  assign bus.grant = r_grant;
  assign bus.sel   = r_sel;
  assign bus.dout  = r_dout;
  assign bus.valid = r_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed literal scenarios plus
// randomized traffic compared every cycle against a behavioural owner model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic chk_en = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  mux4_rr_arbiter_if bus();

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an owner index (-1 = none), a rotation start and a hold count.
  int         m_owner;
  int         m_ptr;
  logic [3:0] m_grant;
  logic [1:0] m_sel;
  logic       m_dout;
  logic       m_valid;
`ifdef ARB_TIMEOUT_EN
  int         m_hold;
`endif

  function automatic int first_from(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic grant_to(input int k);
    m_owner = k;
    m_grant = 4'(1 << k);
    m_sel   = 2'(k);
    m_ptr   = (k + 1) % 4;
`ifdef ARB_TIMEOUT_EN
    m_hold  = 0;
`endif
  endtask

  always @(posedge clk) begin
    int nxt;
    if (!reset_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_grant = 4'b0000;
      m_sel   = 2'b00;
      m_dout  = 1'b0;
      m_valid = 1'b0;
`ifdef ARB_TIMEOUT_EN
      m_hold  = 0;
`endif
    end else if (m_owner < 0) begin
      m_valid = 1'b0;
      nxt = first_from(bus.req, m_ptr);
      if (nxt >= 0) grant_to(nxt);
    end else begin
      m_dout  = bus.din[m_owner];
      m_valid = 1'b1;
      if (bus.req[m_owner]) begin
`ifdef ARB_TIMEOUT_EN
        if (m_hold == MAX_HOLD - 1) begin
          nxt = first_from(bus.req & ~(4'b0001 << m_owner), m_ptr);
          if (nxt >= 0) grant_to(nxt);
          else m_hold = 0;
        end else begin
          m_hold++;
        end
`endif
      end else begin
        nxt = first_from(bus.req, m_ptr);
        if (nxt >= 0) grant_to(nxt);
        else begin
          m_owner = -1;
          m_grant = 4'b0000;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant", 8'(bus.grant), 8'(m_grant));
      check("sel",   8'(bus.sel),   8'(m_sel));
      check("dout",  8'(bus.dout),  8'(m_dout));
      check("valid", 8'(bus.valid), 8'(m_valid));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  logic [3:0] rr_exp [5];
  logic [3:0] exp_g;
  int         c;

  initial begin
    reset_n = 1'b0;
    bus.req = 4'b1111;
    bus.din = 4'b0000;

    // Reset held two edges with all requests pending.
    step();
    chk_en = 1'b1;
    step();
    check("rst_grant", 8'(bus.grant), 8'h00);
    check("rst_sel",   8'(bus.sel),   8'h00);
    check("rst_valid", 8'(bus.valid), 8'h00);
    check("rst_dout",  8'(bus.dout),  8'h00);
    check("model_rst_grant", 8'(m_grant), 8'h00);
    reset_n = 1'b1;
    step();
    check("post_rst_grant", 8'(bus.grant), 8'h01);
    check("post_rst_sel",   8'(bus.sel),   8'h00);

    // Single requester 2.
    bus.req = 4'b0000;
    step();
    step();
    check("idle_grant", 8'(bus.grant), 8'h00);
    check("idle_valid", 8'(bus.valid), 8'h00);
    bus.req = 4'b0100;
    bus.din = 4'b0100;
    step();
    check("single_grant", 8'(bus.grant), 8'h04);
    check("single_sel",   8'(bus.sel),   8'h02);
    check("single_valid0", 8'(bus.valid), 8'h00);
    step();
    check("single_valid1", 8'(bus.valid), 8'h01);
    check("single_dout1",  8'(bus.dout),  8'h01);
    step();
    check("single_dout2",  8'(bus.dout),  8'h01);
    bus.req = 4'b0000;
    step();
    check("drop_grant", 8'(bus.grant), 8'h00);
    check("drop_valid", 8'(bus.valid), 8'h01);
    step();
    check("drop_valid2", 8'(bus.valid), 8'h00);
    check("drop_dout",   8'(bus.dout),  8'h01);
    check("drop_sel",    8'(bus.sel),   8'h02);

    // Round-robin: each owner drops its request after one cycle.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    bus.req = 4'b1111;
    bus.din = 4'b1010;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    step();
    check("rr_0", 8'(bus.grant), 8'(rr_exp[0]));
    for (int k = 1; k < 5; k++) begin
      bus.req = 4'b1111 & ~rr_exp[k-1];
      step();
      check($sformatf("rr_%0d", k), 8'(bus.grant), 8'(rr_exp[k]));
      check($sformatf("model_rr_%0d", k), 8'(m_grant), 8'(rr_exp[k]));
    end

    // Fairness: owner 2 releases with 0011 pending, pointer wraps to 0.
    bus.req = 4'b0100;
    step();
    check("fair_own2", 8'(bus.grant), 8'h04);
    bus.req = 4'b0011;
    step();
    check("fair_wrap", 8'(bus.grant), 8'h01);

    // Constant contention 0011: current cycle is owner 0's first.
    for (int i = 0; i < 11; i++) begin
      step();
      c = i + 1;
`ifdef ARB_TIMEOUT_EN
      exp_g = ((c / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      check($sformatf("hold_%0d", c), 8'(bus.grant), 8'(exp_g));
    end

    // Reset in the middle of an owner-3 transfer.
    bus.req = 4'b1000;
    bus.din = 4'b1000;
    step();
    check("own3_grant", 8'(bus.grant), 8'h08);
    check("own3_sel",   8'(bus.sel),   8'h03);
    step();
    check("own3_valid", 8'(bus.valid), 8'h01);
    check("own3_dout",  8'(bus.dout),  8'h01);
    reset_n = 1'b0;
    step();
    check("midrst_grant", 8'(bus.grant), 8'h00);
    check("midrst_sel",   8'(bus.sel),   8'h00);
    check("midrst_valid", 8'(bus.valid), 8'h00);
    check("midrst_dout",  8'(bus.dout),  8'h00);
    reset_n = 1'b1;
    step();
    check("rerst_grant", 8'(bus.grant), 8'h08);
    check("rerst_sel",   8'(bus.sel),   8'h03);

    // Randomized traffic: sticky requests, random data, rare resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.din = 4'($urandom_range(0, 15));
      reset_n = ($urandom_range(0, 149) != 0);
      step();
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
